// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_access_ctrl
// Brief    : Arbitrates the 8x16 register file's write port and SR1 read port
//            between CPU writeback and a debug requester (write, read,
//            clear-all, dump-all over a req/ack handshake). CPU writes always
//            win; the CPU is stalled while debug owns SR1 or a clear runs.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_access_ctrl #(
    parameter int W    = 16,
    parameter int NREG = 8
) (
    input  logic         clk,
    input  logic         reset,
    // CPU datapath side
    input  logic         cpu_ld_reg,
    input  logic [2:0]   cpu_dr,
    input  logic [2:0]   cpu_sr1,
    input  logic [2:0]   cpu_sr2,
    input  logic [W-1:0] cpu_d_in,
    output logic         cpu_stall,
    // Debug requester side
    input  logic         dbg_req,
    input  logic [1:0]   dbg_op,
    input  logic [2:0]   dbg_addr,
    input  logic [W-1:0] dbg_wdata,
    output logic         dbg_busy,
    output logic         dbg_ack,
    output logic         dbg_rvalid,
    output logic [W-1:0] dbg_rdata,
    output logic [2:0]   dbg_rindex,
    // Register file side
    output logic         rf_ld_reg,
    output logic [2:0]   rf_dr,
    output logic [2:0]   rf_sr1,
    output logic [2:0]   rf_sr2,
    output logic [W-1:0] rf_d_in,
    input  logic [W-1:0] rf_sr1_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_CLEAR = 3'd3,
        S_DUMP  = 3'd4,
        S_ACK   = 3'd5
    } state_t;

    localparam logic [1:0] c_OP_WRITE = 2'b00;
    localparam logic [1:0] c_OP_READ  = 2'b01;
    localparam logic [1:0] c_OP_CLEAR = 2'b10;
    localparam logic [2:0] c_LAST_IDX = 3'(NREG - 1);

    state_t         r_state;
    logic [2:0]     r_addr;
    logic [W-1:0]   r_wdata;
    logic [2:0]     r_idx;
    logic           r_ack;
    logic           r_rvalid;
    logic [W-1:0]   r_rdata;
    logic [2:0]     r_rindex;

    // Register-file port mux: CPU pass-through unless debug owns a port this cycle
    always_comb begin
        rf_ld_reg = cpu_ld_reg;
        rf_dr     = cpu_dr;
        rf_d_in   = cpu_d_in;
        rf_sr1    = cpu_sr1;
        case (r_state)
            S_WRITE: begin
                if (!cpu_ld_reg) begin
                    rf_ld_reg = 1'b1;
                    rf_dr     = r_addr;
                    rf_d_in   = r_wdata;
                end
            end
            S_CLEAR: begin
                if (!cpu_ld_reg) begin
                    rf_ld_reg = 1'b1;
                    rf_dr     = r_idx;
                    rf_d_in   = '0;
                end
            end
            S_READ:  rf_sr1 = r_addr;
            S_DUMP:  rf_sr1 = r_idx;
            default: ;
        endcase
    end

    assign rf_sr2     = cpu_sr2;
    assign cpu_stall  = (r_state == S_READ) || (r_state == S_DUMP) || (r_state == S_CLEAR);
    assign dbg_busy   = (r_state != S_IDLE);
    assign dbg_ack    = r_ack;
    assign dbg_rvalid = r_rvalid;
    assign dbg_rdata  = r_rdata;
    assign dbg_rindex = r_rindex;

    // Debug FSM: accepts a request, sequences the operation, then acks for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_idx    <= '0;
            r_ack    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rindex <= '0;
        end else begin
            // ack and rvalid are single-cycle pulses unless re-asserted below
            r_ack    <= 1'b0;
            r_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dbg_req) begin
                        r_addr  <= dbg_addr;
                        r_wdata <= dbg_wdata;
                        r_idx   <= '0;
                        case (dbg_op)
                            c_OP_WRITE: r_state <= S_WRITE;
                            c_OP_READ:  r_state <= S_READ;
                            c_OP_CLEAR: r_state <= S_CLEAR;
                            default:    r_state <= S_DUMP;
                        endcase
                    end
                end
                S_WRITE: begin
                    // the mux performs the write in this same cycle when the CPU is quiet
                    if (!cpu_ld_reg) begin
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end
                end
                S_READ: begin
                    r_rdata  <= rf_sr1_out;
                    r_rindex <= r_addr;
                    r_rvalid <= 1'b1;
                    r_ack    <= 1'b1;
                    r_state  <= S_ACK;
                end
                S_CLEAR: begin
                    // a CPU write steals the cycle, so the clear index holds
                    if (!cpu_ld_reg) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_ack   <= 1'b1;
                            r_state <= S_ACK;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                S_DUMP: begin
                    // reads never conflict with the CPU write port, so no stalling here
                    r_rdata  <= rf_sr1_out;
                    r_rindex <= r_idx;
                    r_rvalid <= 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_access_ctrl
// Brief    : Self-checking bench for regfile_access_ctrl with a behavioural
//            register file, a reference model and a read/ack scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_access_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_ld_reg = 1'b0;
    logic [2:0]   cpu_dr = '0, cpu_sr1 = '0, cpu_sr2 = '0;
    logic [W-1:0] cpu_d_in = '0;
    logic         cpu_stall;
    logic         dbg_req = 1'b0;
    logic [1:0]   dbg_op = '0;
    logic [2:0]   dbg_addr = '0;
    logic [W-1:0] dbg_wdata = '0;
    logic         dbg_busy, dbg_ack, dbg_rvalid;
    logic [W-1:0] dbg_rdata;
    logic [2:0]   dbg_rindex;
    logic         rf_ld_reg;
    logic [2:0]   rf_dr, rf_sr1, rf_sr2;
    logic [W-1:0] rf_d_in;
    logic [W-1:0] rf_sr1_out;

    regfile_access_ctrl #(.W(W), .NREG(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_ld_reg(cpu_ld_reg), .cpu_dr(cpu_dr), .cpu_sr1(cpu_sr1), .cpu_sr2(cpu_sr2),
        .cpu_d_in(cpu_d_in), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_busy(dbg_busy), .dbg_ack(dbg_ack), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .dbg_rindex(dbg_rindex),
        .rf_ld_reg(rf_ld_reg), .rf_dr(rf_dr), .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
        .rf_d_in(rf_d_in), .rf_sr1_out(rf_sr1_out)
    );

    always #5 clk = ~clk;

    // Behavioural 8x16 register file: synchronous write, combinational SR1 read
    logic [W-1:0] rf_mem [8];
    always @(posedge clk) if (rf_ld_reg) rf_mem[rf_dr] <= rf_d_in;
    assign rf_sr1_out = rf_mem[rf_sr1];

    int n_vec = 0;
    int n_bad = 0;

    // Scoreboard queues and reference register contents
    logic [2:0]   exp_idx[$];
    logic [W-1:0] exp_data[$];
    bit           exp_ack[$];
    logic [W-1:0] mdl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected read result on every rvalid and the expected ack kind on every ack
    logic [2:0]   m_idx;
    logic [W-1:0] m_data;
    bit           m_ack;
    always @(negedge clk) begin
        if (dbg_rvalid) begin
            if (exp_idx.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_rvalid: got rindex %0d rdata %0h, none expected", dbg_rindex, dbg_rdata);
            end else begin
                m_idx  = exp_idx.pop_front();
                m_data = exp_data.pop_front();
                check("rindex", dbg_rindex, m_idx);
                check("rdata", dbg_rdata, m_data);
            end
        end
        if (dbg_ack) begin
            if (exp_ack.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_ack: got ack at %0t, none expected", $time);
            end else begin
                m_ack = exp_ack.pop_front();
                check("ack_with_rvalid", dbg_rvalid, m_ack);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CPU writeback while the debug side is idle
    task automatic cpu_write(input logic [2:0] dr, input logic [W-1:0] d);
        cpu_ld_reg = 1'b1; cpu_dr = dr; cpu_d_in = d;
        tick();
        cpu_ld_reg = 1'b0;
        mdl[dr] = d;
    endtask

    // One debug operation, optionally with a CPU write window over cycles [cs, cs+cn).
    // Cycle 0 is the request cycle; the model walks cycles 1.. applying the rules.
    task automatic run_op(input logic [1:0] op, input logic [2:0] addr, input logic [W-1:0] wd,
                          input int cs, input int cn, input logic [2:0] cdr, input logic [W-1:0] cdata);
        int ack_c, need, free_n, cyc, last_c, k;
        bit in_cpu;
        logic [W-1:0] m [8];
        logic [2:0] e_sr1;
        m = mdl;
        // expected ack cycle
        if (op == 2'b01) ack_c = 2;
        else if (op == 2'b11) ack_c = 9;
        else begin
            need = (op == 2'b00) ? 1 : 8;
            free_n = 0; cyc = 0;
            while (free_n < need) begin
                cyc++;
                if (!(cyc >= cs && cyc < cs + cn)) free_n++;
            end
            ack_c = cyc + 1;
        end
        last_c = (cs + cn - 1 > ack_c) ? cs + cn - 1 : ack_c;
        // expected register traffic
        k = 0;
        for (int c = 1; c <= last_c; c++) begin
            in_cpu = (c >= cs) && (c < cs + cn);
            if (op == 2'b01 && c == 1) begin exp_idx.push_back(addr); exp_data.push_back(m[addr]); end
            if (op == 2'b11 && c <= 8) begin exp_idx.push_back(3'(c - 1)); exp_data.push_back(m[c - 1]); end
            if (op == 2'b00 && c < ack_c && !in_cpu) m[addr] = wd;
            if (op == 2'b10 && c < ack_c && !in_cpu) begin m[k] = '0; k++; end
            if (in_cpu) m[cdr] = cdata;
        end
        exp_ack.push_back(op == 2'b01 || op == 2'b11);
        mdl = m;
        // drive
        dbg_req = 1'b1; dbg_op = op; dbg_addr = addr; dbg_wdata = wd;
        tick();
        dbg_req = 1'b0;
        for (int c = 1; c <= last_c + 1; c++) begin
            in_cpu = (c >= cs) && (c < cs + cn);
            cpu_ld_reg = in_cpu; cpu_dr = cdr; cpu_d_in = cdata;
            cpu_sr1 = 3'($urandom); cpu_sr2 = 3'($urandom);
            dbg_op = 2'($urandom); dbg_addr = 3'($urandom); dbg_wdata = W'($urandom);
            #1;
            if (op == 2'b01 && c == 1) e_sr1 = addr;
            else if (op == 2'b11 && c <= 8) e_sr1 = 3'(c - 1);
            else e_sr1 = cpu_sr1;
            check("ack_cycle", dbg_ack, c == ack_c);
            check("busy", dbg_busy, c <= ack_c);
            check("cpu_stall", cpu_stall, (op != 2'b00) && (c < ack_c));
            check("rf_sr1", rf_sr1, e_sr1);
            check("rf_sr2", rf_sr2, cpu_sr2);
            tick();
        end
        cpu_ld_reg = 1'b0;
    endtask

    initial begin
        logic [1:0] rop;
        int rcs, rcn;
        // reset state
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_busy", dbg_busy, 0);
        check("rst_ack", dbg_ack, 0);
        check("rst_rvalid", dbg_rvalid, 0);
        check("rst_rdata", dbg_rdata, 0);
        check("rst_rindex", dbg_rindex, 0);
        check("rst_stall", cpu_stall, 0);
        tick();

        // initialise all registers, then CPU R3=BEEF and debug read of R3
        for (int i = 0; i < 8; i++) cpu_write(3'(i), 16'h1000 + 16'(i));
        cpu_write(3'd3, 16'hBEEF);
        run_op(2'b01, 3'd3, '0, 0, 0, 3'd0, '0);

        // debug write R5 while the CPU writes R2 for two cycles
        run_op(2'b00, 3'd5, 16'h1234, 1, 2, 3'd2, 16'h00AA);
        run_op(2'b01, 3'd2, '0, 0, 0, 3'd0, '0);
        run_op(2'b01, 3'd5, '0, 0, 0, 3'd0, '0);

        // reload and dump
        for (int i = 0; i < 8; i++) cpu_write(3'(i), 16'h1000 + 16'(i));
        run_op(2'b11, 3'd0, '0, 0, 0, 3'd0, '0);

        // clear with a CPU write of R1 injected while idx=4, then dump
        run_op(2'b10, 3'd0, '0, 5, 1, 3'd1, 16'h5555);
        run_op(2'b11, 3'd0, '0, 0, 0, 3'd0, '0);

        // reset mid-dump while idx=3 is being read: only indices 0..2 are reported, no ack
        for (int i = 0; i < 8; i++) cpu_write(3'(i), 16'h2000 + 16'(i));
        for (int i = 0; i < 3; i++) begin exp_idx.push_back(3'(i)); exp_data.push_back(mdl[i]); end
        dbg_req = 1'b1; dbg_op = 2'b11;
        tick();
        dbg_req = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", dbg_busy, 0);
        check("mid_rst_rvalid", dbg_rvalid, 0);
        check("mid_rst_rdata", dbg_rdata, 0);
        check("mid_rst_ack", dbg_ack, 0);
        tick();

        // request held high through ACK is accepted again in the following IDLE cycle
        repeat (2) begin exp_idx.push_back(3'd6); exp_data.push_back(mdl[6]); exp_ack.push_back(1'b1); end
        dbg_req = 1'b1; dbg_op = 2'b01; dbg_addr = 3'd6;
        tick();
        tick();
        check("held_ack1", dbg_ack, 1);
        tick();
        check("held_idle_busy", dbg_busy, 0);
        tick();
        check("held_reaccept_busy", dbg_busy, 1);
        dbg_req = 1'b0;
        tick();
        check("held_ack2", dbg_ack, 1);
        tick();

        // randomized operations with random CPU write windows
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) cpu_write(3'($urandom), W'($urandom));
            rop = 2'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rcs = $urandom_range(1, 4);
                rcn = $urandom_range(1, 3);
            end else begin
                rcs = 0; rcn = 0;
            end
            run_op(rop, 3'($urandom), W'($urandom), rcs, rcn, 3'($urandom), W'($urandom));
        end

        // final dump confirms register contents against the model
        run_op(2'b11, 3'd0, '0, 0, 0, 3'd0, '0);
        tick(); tick();
        check("rd_queue_drained", exp_idx.size(), 0);
        check("ack_queue_drained", exp_ack.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
